// File: rtl/vdp_super_vram_arbiter.sv
// Slot-based arbiter for the 32-bit super-res VRAM port: display, CPU and command engine.
// Define VDP_SUPER_ARB_REFRESH_EN to reserve the slot decided at cx==720 for refresh.
module vdp_super_vram_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic [9:0]  cx,
    input  logic        super_res_drawing,
    input  logic [16:0] display_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [16:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        cmd_ack,
    output logic [31:0] cmd_rdata,
    input  logic [31:0] vrm_32,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_cs,
    output logic        mem_refresh,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {OwnNone = 2'd0, OwnDisplay = 2'd1, OwnCpu = 2'd2, OwnCmd = 2'd3}
        owner_e;

    owner_e      owner_q, owner_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        refresh_q, refresh_d;
    logic [3:0]  cpu_wait_q, cpu_wait_d;
    logic [3:0]  cmd_wait_q, cmd_wait_d;
    logic        cpu_next_q, cpu_next_d;  // 1: cpu wins the next tie
    logic        cpu_ack_q, cpu_ack_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] cmd_rdata_q, cmd_rdata_d;

    logic [1:0]  phase;
    logic        refresh_slot;
    logic        cpu_aged, cmd_aged;
    logic        grant_cpu, grant_cmd;

    assign phase = cx[1:0];

`ifdef VDP_SUPER_ARB_REFRESH_EN
    assign refresh_slot = (cx == 10'd720);
`else
    logic unused_cx;
    assign unused_cx    = ^cx[9:2];
    assign refresh_slot = 1'b0;
`endif

    // An aged requester only wins if the other one is not equally aged.
    assign cpu_aged = cpu_req && (cpu_wait_q == 4'hF) && !(cmd_req && (cmd_wait_q == 4'hF));
    assign cmd_aged = cmd_req && (cmd_wait_q == 4'hF) && !(cpu_req && (cpu_wait_q == 4'hF));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= OwnNone;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            refresh_q   <= 1'b0;
            cpu_wait_q  <= '0;
            cmd_wait_q  <= '0;
            cpu_next_q  <= 1'b1;
            cpu_ack_q   <= 1'b0;
            cmd_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            cmd_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            refresh_q   <= refresh_d;
            cpu_wait_q  <= cpu_wait_d;
            cmd_wait_q  <= cmd_wait_d;
            cpu_next_q  <= cpu_next_d;
            cpu_ack_q   <= cpu_ack_d;
            cmd_ack_q   <= cmd_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            cmd_rdata_q <= cmd_rdata_d;
        end
    end

    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        refresh_d   = refresh_q;
        cpu_wait_d  = cpu_wait_q;
        cmd_wait_d  = cmd_wait_q;
        cpu_next_d  = cpu_next_q;
        cpu_ack_d   = 1'b0;
        cmd_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        cmd_rdata_d = cmd_rdata_q;
        grant_cpu   = 1'b0;
        grant_cmd   = 1'b0;

        // Completion edge: read data is valid in phase 3, ack shows in the following phase 0.
        if (phase == 2'd3) begin
            refresh_d = 1'b0;
            if (owner_q == OwnCpu) begin
                cpu_ack_d = 1'b1;
                if (!we_q) cpu_rdata_d = vrm_32;
            end
            if (owner_q == OwnCmd) begin
                cmd_ack_d = 1'b1;
                if (!we_q) cmd_rdata_d = vrm_32;
            end
        end

        if (phase == 2'd0) begin
            owner_d   = OwnNone;
            addr_d    = '0;
            wdata_d   = '0;
            be_d      = '0;
            we_d      = 1'b0;
            refresh_d = 1'b0;
            if (vdp_super) begin
                if (refresh_slot) begin
                    refresh_d = 1'b1;
                end else if (super_res_drawing) begin
                    owner_d = OwnDisplay;
                end else if (cpu_aged) begin
                    grant_cpu = 1'b1;
                end else if (cmd_aged) begin
                    grant_cmd = 1'b1;
                end else if (cpu_req && cmd_req) begin
                    grant_cpu = cpu_next_q;
                    grant_cmd = !cpu_next_q;
                end else begin
                    grant_cpu = cpu_req;
                    grant_cmd = cmd_req;
                end

                if (grant_cpu) begin
                    cpu_wait_d = '0;
                end else if (cpu_req && (cpu_wait_q != 4'hF)) begin
                    cpu_wait_d = cpu_wait_q + 4'd1;
                end
                if (grant_cmd) begin
                    cmd_wait_d = '0;
                end else if (cmd_req && (cmd_wait_q != 4'hF)) begin
                    cmd_wait_d = cmd_wait_q + 4'd1;
                end
            end

            if (grant_cpu) begin
                owner_d    = OwnCpu;
                addr_d     = cpu_addr;
                wdata_d    = cpu_wdata;
                be_d       = cpu_be;
                we_d       = cpu_we;
                cpu_next_d = 1'b0;
            end else if (grant_cmd) begin
                owner_d    = OwnCmd;
                addr_d     = cmd_addr;
                wdata_d    = cmd_wdata;
                be_d       = cmd_be;
                we_d       = cmd_we;
                cpu_next_d = 1'b1;
            end
        end
    end

    // Display owns the bus with a live address: the fetcher advances it at the phase-0 edge.
    always_comb begin
        owner       = owner_q;
        mem_cs      = (owner_q != OwnNone);
        mem_we      = we_q;
        mem_be      = be_q;
        mem_wdata   = wdata_q;
        mem_addr    = (owner_q == OwnDisplay) ? display_addr : addr_q;
        mem_refresh = refresh_q;
        cpu_ack     = cpu_ack_q;
        cmd_ack     = cmd_ack_q;
        cpu_rdata   = cpu_rdata_q;
        cmd_rdata   = cmd_rdata_q;
    end

endmodule
